logic_eval_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 3-input logic evaluation unit (inputs d, x, a; output l) between N requesters. It grants one requester at a time and drives that requester's operands onto the unit. It waits a programmable settle time, samples l, and returns the result tagged with the requester index. It sits between requester blocks and the single evaluation unit instance.

---
 rtl/logic_eval_arb.sv | 130 +++++++++++++
 tb/tb_logic_eval_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/logic_eval_arb.sv
// Round-robin arbiter that time-shares one 3-input logic evaluation unit
// between N requesters and returns each sampled result tagged with its requester index.
module logic_eval_arb #(
  parameter int N      = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [3*N-1:0]   ops,
  output logic [N-1:0]     gnt,
  output logic             unit_d,
  output logic             unit_x,
  output logic             unit_a,
  input  logic             unit_l,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic             resp_l,
  output logic             busy
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [2:0]       unit_q, unit_d_q;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic             resp_l_q, resp_l_d;
  logic             busy_q, busy_d;

  // Round-robin pick: scan from ptr upward with wrap; lowest offset wins.
  int   win_idx;
  logic win_found;
  always_comb begin
    int idx;
    win_idx   = 0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        win_idx   = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    unit_d_q     = unit_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_l_d     = resp_l_q;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d    = N'(1) << win_idx;
          unit_d_q = ops[3*win_idx +: 3];
          id_d     = IDW'(win_idx);
          cnt_d    = 4'(SETTLE - 1);
          busy_d   = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_l_d     = unit_l;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          busy_d       = 1'b0;
          ptr_d        = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      unit_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_l_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      unit_q       <= unit_d_q;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_l_q     <= resp_l_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign unit_d     = unit_q[2];
  assign unit_x     = unit_q[1];
  assign unit_a     = unit_q[0];
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_l     = resp_l_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_logic_eval_arb.sv
// Directed bench for logic_eval_arb with N=4, SETTLE=2 and unit model l = d & ~x.
module tb_logic_eval_arb;

  localparam int N      = 4;
  localparam int IDW    = 2;
  localparam int SETTLE = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [3*N-1:0] ops;
  logic [N-1:0]   gnt;
  logic           unit_d, unit_x, unit_a, unit_l;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic           resp_l;
  logic           busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign unit_l = unit_d & ~unit_x;

  logic_eval_arb #(.N(N), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ops(ops), .gnt(gnt),
    .unit_d(unit_d), .unit_x(unit_x), .unit_a(unit_a), .unit_l(unit_l),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_l(resp_l), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    ops   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if ({unit_d, unit_x, unit_a} !== 3'b000) begin bad++; $display("FAIL reset_unit got=%b exp=000", {unit_d, unit_x, unit_a}); end
    total++; if ({resp_valid, resp_id, resp_l, busy} !== 5'b0) begin bad++; $display("FAIL reset_resp got=%b exp=00000", {resp_valid, resp_id, resp_l, busy}); end
  endtask

  task automatic test_single();
    req = 4'b0001;
    ops = '0;
    ops[2:0] = 3'b101;
    tick();
    req = '0;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++; if ({unit_d, unit_x, unit_a} !== 3'b101) begin bad++; $display("FAIL single_unit got=%b exp=101", {unit_d, unit_x, unit_a}); end
    total++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL single_busy0 got=%b%b exp=10", busy, resp_valid); end
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL single_hold got=%b/%b/%b exp=0000/1/0", gnt, busy, resp_valid); end
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_l !== 1'b1) begin bad++; $display("FAIL single_resp got=%b/%0d/%b exp=1/0/1", resp_valid, resp_id, resp_l); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    tick();
    total++; if (resp_valid !== 1'b0 || {unit_d, unit_x, unit_a} !== 3'b101) begin bad++; $display("FAIL single_after got=%b/%b exp=0/101", resp_valid, {unit_d, unit_x, unit_a}); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_l;
    apply_reset();
    // ops: 0={1,0,1} 1={1,0,0} 2={1,1,0} 3={0,0,1}
    ops   = {3'b001, 3'b110, 3'b100, 3'b101};
    exp_l = 4'b0011;
    req   = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tick();
      req[i] = 1'b0;
      total++; if (gnt !== (4'b0001 << i)) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, 4'b0001 << i); end
      tick();
      total++; if (gnt !== 4'b0000 || resp_valid !== 1'b0) begin bad++; $display("FAIL rr_mid%0d got=%b/%b exp=0000/0", i, gnt, resp_valid); end
      tick();
      total++; if (resp_valid !== 1'b1 || resp_id !== IDW'(i) || resp_l !== exp_l[i]) begin bad++; $display("FAIL rr_resp%0d got=%b/%0d/%b exp=1/%0d/%b", i, resp_valid, resp_id, resp_l, i, exp_l[i]); end
    end
  endtask

  task automatic test_fairness();
    req = 4'b1001;
    ops = {3'b100, 3'b000, 3'b000, 3'b110};
    tick();
    req[0] = 1'b0;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL fair_first got=%b exp=0001", gnt); end
    tick();
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_l !== 1'b0) begin bad++; $display("FAIL fair_resp0 got=%b/%0d/%b exp=1/0/0", resp_valid, resp_id, resp_l); end
    tick();
    req[3] = 1'b0;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL fair_second got=%b exp=1000", gnt); end
    tick();
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_l !== 1'b1) begin bad++; $display("FAIL fair_resp3 got=%b/%0d/%b exp=1/3/1", resp_valid, resp_id, resp_l); end
  endtask

  task automatic test_stability();
    req = 4'b0100;
    ops = '0;
    ops[8:6] = 3'b101;
    tick();
    req = '0;
    total++; if (gnt !== 4'b0100 || {unit_d, unit_x, unit_a} !== 3'b101) begin bad++; $display("FAIL stab_grant got=%b/%b exp=0100/101", gnt, {unit_d, unit_x, unit_a}); end
    ops[8:6] = 3'b011;
    tick();
    total++; if ({unit_d, unit_x, unit_a} !== 3'b101) begin bad++; $display("FAIL stab_hold got=%b exp=101", {unit_d, unit_x, unit_a}); end
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_l !== 1'b1) begin bad++; $display("FAIL stab_resp got=%b/%0d/%b exp=1/2/1", resp_valid, resp_id, resp_l); end
  endtask

  task automatic test_reset_mid();
    // ptr is 3 here: order 3,0,1 picks requester 1.
    req = 4'b0010;
    ops = '0;
    ops[5:3] = 3'b111;
    tick();
    req = '0;
    total++; if (gnt !== 4'b0010 || busy !== 1'b1) begin bad++; $display("FAIL rst_mid_grant got=%b/%b exp=0010/1", gnt, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({gnt, unit_d, unit_x, unit_a, resp_valid, resp_id, resp_l, busy} !== 12'b0) begin bad++; $display("FAIL rst_mid_clear got=%b exp=0", {gnt, unit_d, unit_x, unit_a, resp_valid, resp_id, resp_l, busy}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_noresp%0d got=%b/%b exp=0/0", i, resp_valid, busy); end
    end
    req = 4'b1001;
    ops = '0;
    tick();
    req = '0;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_mid_ptr got=%b exp=0001", gnt); end
    tick();
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin bad++; $display("FAIL rst_mid_resp got=%b/%0d exp=1/0", resp_valid, resp_id); end
  endtask

  task automatic test_withdrawal();
    // ptr is 1; only requester 0 asks, then 1 and 2 arrive during its HOLD.
    req = 4'b0001;
    ops = {3'b000, 3'b100, 3'b100, 3'b000};
    tick();
    req = 4'b0110;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wd_grant0 got=%b exp=0001", gnt); end
    tick();
    req = 4'b0100;
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_l !== 1'b0) begin bad++; $display("FAIL wd_resp0 got=%b/%0d/%b exp=1/0/0", resp_valid, resp_id, resp_l); end
    tick();
    req = '0;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL wd_grant2 got=%b exp=0100", gnt); end
    tick();
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_l !== 1'b1) begin bad++; $display("FAIL wd_resp2 got=%b/%0d/%b exp=1/2/1", resp_valid, resp_id, resp_l); end
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b/%b exp=0000/0", gnt, busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ops   = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_stability();
    test_reset_mid();
    test_withdrawal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
